// File: rtl/cv32e40p_pkg2_ft.sv
// Shared definitions for the fault-tolerance error manager: parameter defaults,
// FSM state encoding and register map offsets.
package cv32e40p_pkg2_ft;

  localparam int FTMGR_N_BLOCKS     = 4;
  localparam int FTMGR_CNT_WIDTH    = 16;
  localparam int FTMGR_FORCE_CYCLES = 2;
  localparam int FTMGR_ACK_TIMEOUT  = 15;

  // Encoding is software-visible through STATUS[1:0].
  typedef enum logic [1:0] {
    FT_IDLE     = 2'd0,
    FT_FORCE    = 2'd1,
    FT_WAIT_ACK = 2'd2
  } ft_state_e;

  localparam logic [4:0] FTMGR_OFF_STATUS  = 5'h00;
  localparam logic [4:0] FTMGR_OFF_DET_CNT = 5'h04;
  localparam logic [4:0] FTMGR_OFF_COR_CNT = 5'h08;
  localparam logic [4:0] FTMGR_OFF_BROKEN  = 5'h0C;
  localparam logic [4:0] FTMGR_OFF_FORCE   = 5'h10;
  localparam logic [4:0] FTMGR_OFF_IRQ     = 5'h14;

endpackage

// File: rtl/cv32e40p_ft_sat_counter.sv
// Event counter that adds a small increment every cycle and sticks at all-ones
// instead of wrapping.
module cv32e40p_ft_sat_counter #(
  parameter int WIDTH     = 16,
  parameter int INC_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [INC_WIDTH-1:0] inc,
  output logic [WIDTH-1:0]     count
);

  // One spare bit is enough to detect overflow as long as inc < 2^WIDTH.
  logic [WIDTH:0] sum;

  assign sum = {1'b0, count} + (WIDTH+1)'(inc);

  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      count <= sum[WIDTH] ? '1 : sum[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/cv32e40p_ft_err_manager.sv
// Collects TMR error events from N_BLOCKS protected blocks, exposes them through a
// small register file and can force a replica broken, then wait for confirmation.
module cv32e40p_ft_err_manager
  import cv32e40p_pkg2_ft::*;
#(
  parameter int N_BLOCKS     = FTMGR_N_BLOCKS,
  parameter int CNT_WIDTH    = FTMGR_CNT_WIDTH,
  parameter int FORCE_CYCLES = FTMGR_FORCE_CYCLES,
  parameter int ACK_TIMEOUT  = FTMGR_ACK_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_BLOCKS-1:0]     err_detected_i,
  input  logic [N_BLOCKS-1:0]     err_corrected_i,
  input  logic [3*N_BLOCKS-1:0]   is_broken_i,
  output logic [3*N_BLOCKS-1:0]   set_broken_o,
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [4:0]              addr_i,
  input  logic [31:0]             wdata_i,
  output logic                    gnt_o,
  output logic                    rvalid_o,
  output logic [31:0]             rdata_o,
  output logic                    irq_o
);

  localparam int NB3     = 3 * N_BLOCKS;
  localparam int INC_W   = $clog2(N_BLOCKS + 1);
  localparam int TGT_W   = (NB3 > 1) ? $clog2(NB3) : 1;
  localparam int CYC_MAX = (FORCE_CYCLES > ACK_TIMEOUT) ? FORCE_CYCLES : ACK_TIMEOUT;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);

  ft_state_e          state_q, state_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic [TGT_W-1:0]   tgt_q, tgt_d;
  logic [NB3-1:0]     broken_q;
  logic [2:0]         sticky_q, sticky_d, sticky_set, sticky_clr;
  logic [2:0]         irq_en_q, irq_en_d;
  logic [CNT_WIDTH-1:0] det_cnt, cor_cnt;
  logic               wr_en, rd_en, force_wr, force_ok, irq_wr, timeout_set;
  logic [31:0]        rdata_d;
  logic               unused_wdata;

  assign gnt_o    = req_i;
  assign wr_en    = req_i & we_i;
  assign rd_en    = req_i & ~we_i;
  assign force_wr = wr_en && (addr_i == FTMGR_OFF_FORCE);
  assign irq_wr   = wr_en && (addr_i == FTMGR_OFF_IRQ);
  // Replica index 3 does not exist, so it is rejected like an out-of-range block.
  assign force_ok = (int'(wdata_i[7:2]) < N_BLOCKS) && (wdata_i[1:0] != 2'd3);
  assign unused_wdata = ^wdata_i[31:11];

  cv32e40p_ft_sat_counter #(.WIDTH(CNT_WIDTH), .INC_WIDTH(INC_W)) u_det_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (INC_W'($countones(err_detected_i))),
    .count (det_cnt)
  );

  cv32e40p_ft_sat_counter #(.WIDTH(CNT_WIDTH), .INC_WIDTH(INC_W)) u_cor_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (INC_W'($countones(err_corrected_i))),
    .count (cor_cnt)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    tgt_d       = tgt_q;
    timeout_set = 1'b0;
    unique case (state_q)
      FT_IDLE: begin
        if (force_wr && force_ok) begin
          state_d = FT_FORCE;
          cyc_d   = '0;
          tgt_d   = TGT_W'(int'(wdata_i[7:2]) * 3 + int'(wdata_i[1:0]));
        end
      end
      FT_FORCE: begin
        if (cyc_q == CYC_W'(FORCE_CYCLES - 1)) begin
          state_d = FT_WAIT_ACK;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      FT_WAIT_ACK: begin
        if (is_broken_i[tgt_q]) begin
          state_d = FT_IDLE;
        end else if (cyc_q == CYC_W'(ACK_TIMEOUT - 1)) begin
          state_d     = FT_IDLE;
          timeout_set = 1'b1;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      default: state_d = FT_IDLE;
    endcase
  end

  // Sticky order {new-broken, timeout, uncorrectable}; a same-cycle set beats the W1C clear.
  assign sticky_set = {|(is_broken_i & ~broken_q), timeout_set,
                       |(err_detected_i & ~err_corrected_i)};
  assign sticky_clr = irq_wr ? wdata_i[10:8] : 3'b000;
  assign sticky_d   = (sticky_q & ~sticky_clr) | sticky_set;
  assign irq_en_d   = irq_wr ? wdata_i[2:0] : irq_en_q;

  always_comb begin
    rdata_d = '0;
    if (rd_en) begin
      case (addr_i)
        FTMGR_OFF_STATUS:  rdata_d = 32'({sticky_q, state_q});
        FTMGR_OFF_DET_CNT: rdata_d = 32'(det_cnt);
        FTMGR_OFF_COR_CNT: rdata_d = 32'(cor_cnt);
        FTMGR_OFF_BROKEN:  rdata_d = 32'(is_broken_i);
        FTMGR_OFF_IRQ:     rdata_d = 32'(irq_en_q);
        default:           rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FT_IDLE;
      cyc_q        <= '0;
      tgt_q        <= '0;
      broken_q     <= '0;
      sticky_q     <= '0;
      irq_en_q     <= '0;
      irq_o        <= 1'b0;
      set_broken_o <= '0;
      rvalid_o     <= 1'b0;
      rdata_o      <= '0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      tgt_q        <= tgt_d;
      broken_q     <= is_broken_i;
      sticky_q     <= sticky_d;
      irq_en_q     <= irq_en_d;
      irq_o        <= |(sticky_d & irq_en_d);
      set_broken_o <= (state_d == FT_FORCE) ? (NB3'(1) << tgt_d) : '0;
      rvalid_o     <= req_i;
      rdata_o      <= rdata_d;
    end
  end

endmodule

// File: tb/tb_cv32e40p_ft_err_manager.sv
// Randomized and directed bench for the FT error manager against a cycle-level
// behavioural model built from the register and force/ack rules.
module tb_cv32e40p_ft_err_manager;

  localparam int NB      = 4;
  localparam int NB3     = 3 * NB;
  localparam int FC      = 2;
  localparam int AT      = 15;
  localparam int CNT_MAX = 65535;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NB-1:0]   err_det = '0, err_cor = '0;
  logic [NB3-1:0]  is_broken = '0;
  logic [NB3-1:0]  set_broken_o;
  logic            req = 1'b0, we = 1'b0;
  logic [4:0]      addr = '0;
  logic [31:0]     wdata = '0;
  logic            gnt_o, rvalid_o, irq_o;
  logic [31:0]     rdata_o;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state, phrased in terms of the register map and force protocol.
  int              m_det, m_cor;
  bit              m_unc, m_to, m_nb;
  bit [2:0]        m_en;
  bit [NB3-1:0]    m_shadow, m_set;
  int              m_phase;   // 0 idle, 1 forcing, 2 waiting for ack
  int              m_left;    // cycles remaining in the current phase
  int              m_bit;
  bit              m_irq, m_rvalid;
  bit [31:0]       m_rdata;

  cv32e40p_ft_err_manager dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .err_detected_i  (err_det),
    .err_corrected_i (err_cor),
    .is_broken_i     (is_broken),
    .set_broken_o    (set_broken_o),
    .req_i           (req),
    .we_i            (we),
    .addr_i          (addr),
    .wdata_i         (wdata),
    .gnt_o           (gnt_o),
    .rvalid_o        (rvalid_o),
    .rdata_o         (rdata_o),
    .irq_o           (irq_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_det = 0; m_cor = 0; m_unc = 0; m_to = 0; m_nb = 0; m_en = '0;
    m_shadow = '0; m_set = '0; m_phase = 0; m_left = 0; m_bit = 0;
    m_irq = 0; m_rvalid = 0; m_rdata = '0;
  endtask

  task automatic model_step();
    bit [31:0] rd;
    bit        unc_set, nb_set, to_set;
    bit [2:0]  clr;
    rd = '0;
    if (req && !we) begin
      case (addr)
        5'h00: rd = {27'd0, m_nb, m_to, m_unc, 2'(m_phase)};
        5'h04: rd = m_det;
        5'h08: rd = m_cor;
        5'h0C: rd = 32'(is_broken);
        5'h14: rd = 32'(m_en);
        default: rd = '0;
      endcase
    end
    m_det = m_det + $countones(err_det);
    if (m_det > CNT_MAX) m_det = CNT_MAX;
    m_cor = m_cor + $countones(err_cor);
    if (m_cor > CNT_MAX) m_cor = CNT_MAX;
    unc_set = |(err_det & ~err_cor);
    nb_set  = |(is_broken & ~m_shadow);
    to_set  = 0;
    case (m_phase)
      0: if (req && we && addr == 5'h10 && wdata[7:2] < NB && wdata[1:0] < 3) begin
           m_phase = 1; m_left = FC; m_bit = wdata[7:2] * 3 + wdata[1:0];
         end
      1: begin
           m_left--;
           if (m_left == 0) begin m_phase = 2; m_left = AT; end
         end
      default: begin
           if (is_broken[m_bit]) m_phase = 0;
           else begin
             m_left--;
             if (m_left == 0) begin to_set = 1; m_phase = 0; end
           end
         end
    endcase
    clr = (req && we && addr == 5'h14) ? wdata[10:8] : 3'b000;
    if (req && we && addr == 5'h14) m_en = wdata[2:0];
    m_unc = (m_unc && !clr[0]) || unc_set;
    m_to  = (m_to  && !clr[1]) || to_set;
    m_nb  = (m_nb  && !clr[2]) || nb_set;
    m_shadow = is_broken;
    m_set    = (m_phase == 1) ? (NB3'(1) << m_bit) : '0;
    m_irq    = |({m_nb, m_to, m_unc} & m_en);
    m_rvalid = req;
    m_rdata  = rd;
  endtask

  // One clock: check the combinational grant, advance the model, compare after the edge.
  task automatic cycle();
    #1;
    check("gnt", 32'(gnt_o), 32'(req));
    model_step();
    @(posedge clk);
    #1;
    check("set_broken", 32'(set_broken_o), 32'(m_set));
    check("irq", 32'(irq_o), 32'(m_irq));
    check("rvalid", 32'(rvalid_o), 32'(m_rvalid));
    check("rdata", rdata_o, m_rdata);
  endtask

  task automatic drive_idle();
    req = 0; we = 0; addr = '0; wdata = '0; err_det = '0; err_cor = '0;
  endtask

  task automatic apply_reset();
    drive_idle();
    is_broken = '0;
    rst_n = 0;
    #1;
    check("rst_set_broken", 32'(set_broken_o), 32'h0);
    check("rst_irq", 32'(irq_o), 32'h0);
    check("rst_rvalid", 32'(rvalid_o), 32'h0);
    check("rst_rdata", rdata_o, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    model_reset();
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    req = 1; we = 1; addr = a; wdata = d;
    cycle();
    req = 0; we = 0; wdata = '0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    req = 1; we = 0; addr = a;
    cycle();
    req = 0;
    d = rdata_o;
  endtask

  initial begin
    logic [31:0] d;
    logic [4:0]  addrs [8];
    int          cnt;
    addrs = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h14, 5'h18, 5'h1C};

    // Saturation: 4 events/cycle for 16384 cycles reaches the ceiling and stays.
    apply_reset();
    err_det = 4'b1111;
    repeat (16384) cycle();
    bus_read(5'h04, d);
    check("det_saturated", d, 32'h0000_FFFF);
    repeat (40) cycle();
    bus_read(5'h04, d);
    check("det_no_wrap", d, 32'h0000_FFFF);
    err_det = '0;

    // Force block 2 replica 1 with ack arriving three cycles after the write.
    apply_reset();
    bus_write(5'h14, 32'h4);
    bus_write(5'h10, 32'h9);
    cnt = int'(set_broken_o[7]);
    for (int k = 1; k <= 8; k++) begin
      if (k == 4) is_broken[7] = 1'b1;
      cycle();
      cnt += int'(set_broken_o[7]);
    end
    check("force_pulse_len", 32'(cnt), 32'd2);
    bus_read(5'h00, d);
    check("force_ack_status", d, 32'h10);
    check("force_ack_irq", 32'(irq_o), 32'h1);
    is_broken = '0;

    // Timeout: no confirmation, count cycles spent in WAIT_ACK via STATUS.
    apply_reset();
    bus_write(5'h10, 32'h0);
    cnt = 0;
    for (int k = 0; k < 25; k++) begin
      bus_read(5'h00, d);
      if (d[1:0] == 2'd2) cnt++;
    end
    check("timeout_wait_cycles", 32'(cnt), 32'd15);
    check("timeout_status", d, 32'h8);

    // Uncorrectable set racing a W1C clear of the same bit.
    apply_reset();
    err_det = 4'b0001;
    cycle();
    bus_write(5'h14, 32'h100);
    err_det = '0;
    bus_read(5'h00, d);
    check("race_set_wins", d, 32'h4);
    bus_write(5'h14, 32'h100);
    bus_read(5'h00, d);
    check("w1c_clears", d, 32'h0);

    // Invalid accesses: out-of-range block, unmapped read, write to read-only.
    bus_write(5'h10, 32'(7 << 2));
    bus_write(5'h00, 32'hFFFF_FFFF);
    bus_read(5'h00, d);
    check("bad_force_ignored", d, 32'h0);
    bus_read(5'h18, d);
    check("unmapped_rvalid", 32'(rvalid_o), 32'h1);
    check("unmapped_rdata", d, 32'h0);

    // Reset in the first FORCE cycle, then every register reads zero.
    apply_reset();
    bus_write(5'h14, 32'h7);
    bus_write(5'h10, 32'h6);
    check("midforce_active", 32'(set_broken_o), 32'h20);
    apply_reset();
    for (int k = 0; k < 7; k++) begin
      bus_read(addrs[k], d);
      check("post_reset_read", d, 32'h0);
    end

    // Randomized traffic against the model.
    apply_reset();
    for (int n = 0; n < 3000; n++) begin
      req   = 1'($urandom_range(0, 1));
      we    = 1'($urandom_range(0, 1));
      addr  = ($urandom_range(0, 9) < 8) ? addrs[$urandom_range(0, 7)] : 5'($urandom);
      wdata = $urandom;
      if (addr == 5'h10) wdata[7:0] = {3'b000, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 2))};
      err_det = 4'($urandom);
      err_cor = 4'($urandom);
      if ($urandom_range(0, 7) == 0) is_broken[$urandom_range(0, NB3 - 1)] ^= 1'b1;
      if (m_phase == 2 && $urandom_range(0, 3) == 0) is_broken[m_bit] = 1'b1;
      cycle();
    end
    drive_idle();
    cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cv32e40p_ft_err_manager.md
CV32E40P_FT_ERR_MANAGER -- requirements
Module: cv32e40p_ft_err_manager

Interface
REQ-001 SHALL have parameter N_BLOCKS, default 4: number of TMR-protected blocks monitored.
REQ-002 SHALL have parameter CNT_WIDTH, default 16: width of the error event counters.
REQ-003 SHALL have parameter FORCE_CYCLES, default 2: number of cycles set_broken_o is held per force command.
REQ-004 SHALL have parameter ACK_TIMEOUT, default 15: maximum number of cycles to wait for is_broken_i confirmation.
REQ-005 SHALL have port clk, input, 1 bit: single clock.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port err_detected_i, input, N_BLOCKS bits: per-block err_detected_o.
REQ-008 SHALL have port err_corrected_i, input, N_BLOCKS bits: per-block err_corrected_o.
REQ-009 SHALL have port is_broken_i, input, N_BLOCKS x 3 bits: per-block replica broken flags.
REQ-010 SHALL have port set_broken_o, output, N_BLOCKS x 3 bits: per-block replica force-broken.
REQ-011 SHALL have ports req_i (1 bit), we_i (1 bit), addr_i (5 bits) and wdata_i (32 bits), inputs: register access.
REQ-012 SHALL have ports gnt_o (1 bit), rvalid_o (1 bit) and rdata_o (32 bits), outputs: access response.
REQ-013 SHALL have port irq_o, output, 1 bit: level interrupt.

Function
REQ-014 SHALL drive gnt_o = req_i combinationally; rvalid_o SHALL assert exactly 1 cycle after each granted access; rdata_o SHALL be valid with rvalid_o and 0 otherwise.
REQ-015 SHALL implement registers at the following offsets: 0x00 STATUS (ro), 0x04 DET_CNT (ro), 0x08 COR_CNT (ro), 0x0C BROKEN (ro), 0x10 FORCE (wo), 0x14 IRQ (rw).
- STATUS: [1:0] FSM state, [2] sticky uncorrectable, [3] sticky timeout, [4] sticky new-broken.
- BROKEN: is_broken_i flattened, block b replica r at bit 3b+r.
- FORCE: [7:2] block index, [1:0] replica index.
- IRQ: [2:0] enables; writing 1 to bits [10:8] clears the matching STATUS sticky bits [4:2].
- Reads of unmapped offsets SHALL return 0; writes to them and to read-only registers SHALL be ignored.
REQ-016 DET_CNT SHALL increment by popcount(err_detected_i) each cycle and saturate at 2^CNT_WIDTH-1; COR_CNT SHALL do the same using err_corrected_i; neither SHALL wrap.
REQ-017 Uncorrectable sticky SHALL set when err_detected_i[b] & ~err_corrected_i[b] for any b.
REQ-018 New-broken sticky SHALL set on any 0->1 transition of any is_broken_i bit, compared against a registered copy.
REQ-019 If a sticky set and a W1C clear hit the same bit in the same cycle, the set SHALL win.
REQ-020 irq_o SHALL be registered and equal OR(STATUS[4:2] & IRQ[2:0]).
REQ-021 SHALL implement FSM states IDLE, FORCE, WAIT_ACK with the following transitions:
- IDLE: a FORCE write with block index < N_BLOCKS SHALL latch block/replica and go to FORCE; an out-of-range index SHALL be ignored.
- FORCE: set_broken_o SHALL assert only the latched bit for exactly FORCE_CYCLES cycles, then go to WAIT_ACK.
- WAIT_ACK: the FSM SHALL return to IDLE as soon as the latched is_broken_i bit is 1; if it is still 0 after ACK_TIMEOUT cycles, the FSM SHALL set timeout sticky and return to IDLE.
- FORCE writes outside IDLE SHALL be ignored (no queueing).
REQ-022 set_broken_o SHALL be registered and all-zero outside FORCE.

Reset
REQ-023 On rst_n low, at any time including mid-FORCE, the block SHALL immediately reset to:
- FSM in IDLE;
- set_broken_o, irq_o, rvalid_o, rdata_o = 0;
- counters, sticky bits, IRQ enables and the is_broken_i shadow = 0.

Structure
REQ-024 The FSM state typedef, register offsets and parameter defaults (FTMGR_N_BLOCKS, FTMGR_CNT_WIDTH, FTMGR_FORCE_CYCLES, FTMGR_ACK_TIMEOUT) SHALL live in cv32e40p_pkg2_ft.
REQ-025 Saturating counters SHALL be a sub-module cv32e40p_ft_sat_counter (parameter width, increment input), instantiated twice.

Verification
REQ-026 Saturation: err_detected_i=4'b1111 held for 16384 cycles -> DET_CNT reads 0xFFFF and stays there, with no wrap.
REQ-027 Force and ack: write FORCE=(block 2, replica 1), then model is_broken_i[2][1] rising 3 cycles later -> set_broken_o bit 7 high exactly 2 cycles, FSM back in IDLE, new-broken sticky=1, irq_o=1 if IRQ[2]=1.
REQ-028 Timeout: write FORCE with no is_broken_i response -> 15 cycles in WAIT_ACK, then timeout sticky=1 and IDLE.
REQ-029 Sticky race: err_detected_i[0]=1 with err_corrected_i[0]=0 in the same cycle as a W1C write of bit 8 -> uncorrectable sticky remains 1.
REQ-030 Reset mid-force: rst_n low during FORCE cycle 1 -> set_broken_o=0 immediately, all registers read 0 after release.
REQ-031 Invalid accesses: write FORCE with block index 7 (N_BLOCKS=4) -> no state change; read offset 0x18 -> rvalid_o one cycle later, rdata_o=0.
